// File: rtl/pipe_pkg.sv
// Shared definitions for the reusable pipeline stage register: control bit
// positions and the packed entry width.
package pipe_pkg;

   // Control bit positions inside the ctrl field.
   localparam int CTRL_WE_BIT = 0;
   localparam int CTRL_WE     = 0;   // register write enable
   localparam int CTRL_LW     = 1;   // load-word result select
   localparam int CTRL_LUI    = 2;   // upper-immediate result select

   // Packed entry layout is {data words, rd, ctrl}, ctrl in the LSBs.
   function automatic int entry_w(input int num_data, input int data_w,
                                  input int rd_w, input int ctrl_w);
      return num_data * data_w + rd_w + ctrl_w;
   endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// One pipeline entry: payload plus valid bit. clear wins over load so a
// flush always leaves the entry empty.
module pipe_entry_reg #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic         clear,
   input  logic [W-1:0] d,
   output logic         valid,
   output logic [W-1:0] payload
);

   logic         valid_d, valid_q;
   logic [W-1:0] payload_d, payload_q;

   // Next-state: clear empties the entry, load captures a new payload.
   always_comb begin
      valid_d   = valid_q;
      payload_d = payload_q;
      if (clear) begin
         valid_d = 1'b0;
      end else if (load) begin
         valid_d   = 1'b1;
         payload_d = d;
      end
   end

   // Entry state register with synchronous reset to empty/zero.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q   <= 1'b0;
         payload_q <= '0;
      end else begin
         valid_q   <= valid_d;
         payload_q <= payload_d;
      end
   end

   assign valid   = valid_q;
   assign payload = payload_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, optional skid entry,
// flush, x0 write-enable masking and a saturating stall counter.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int NUM_DATA = 3,
   parameter int RD_W     = 5,
   parameter int CTRL_W   = 3,
   parameter int SKID     = 1,
   parameter int MASK_X0  = 1,
   parameter int CNT_W    = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [NUM_DATA*DATA_W-1:0] in_data,
   input  logic [RD_W-1:0]            in_rd,
   input  logic [CTRL_W-1:0]          in_ctrl,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [NUM_DATA*DATA_W-1:0] out_data,
   output logic [RD_W-1:0]            out_rd,
   output logic [CTRL_W-1:0]          out_ctrl,
   output logic [CNT_W-1:0]           stall_cnt
);

   localparam int EW = entry_w(NUM_DATA, DATA_W, RD_W, CTRL_W);
   localparam int DW = NUM_DATA * DATA_W;

   logic [EW-1:0]    in_payload, main_payload, skid_payload, main_d;
   logic             main_v, skid_v;
   logic             acc, drn;
   logic             main_load, main_clear, skid_load, skid_clear;
   logic [CTRL_W-1:0] head_ctrl;
   logic [RD_W-1:0]   head_rd;
   logic [CNT_W-1:0]  cnt_d, cnt_q;

   assign in_payload = {in_data, in_rd, in_ctrl};

   // Handshake and entry movement; flush blocks acceptance and empties both entries.
   always_comb begin
      in_ready   = 1'b0;
      main_load  = 1'b0;
      main_clear = 1'b0;
      skid_load  = 1'b0;
      skid_clear = 1'b0;
      main_d     = in_payload;
      if (!reset && !flush) begin
         if (SKID != 0) in_ready = !skid_v;
         else           in_ready = !main_v || out_ready;
      end
      acc = in_valid && in_ready;
      drn = main_v && out_ready;
      if (flush) begin
         main_clear = 1'b1;
         skid_clear = 1'b1;
      end else if (drn) begin
         if (skid_v) begin
            // Skid entry is older than anything offered, so it refills MAIN.
            main_d     = skid_payload;
            main_load  = 1'b1;
            skid_clear = 1'b1;
         end else if (acc) begin
            main_load  = 1'b1;
         end else begin
            main_clear = 1'b1;
         end
      end else if (acc) begin
         if (main_v) skid_load = 1'b1;
         else        main_load = 1'b1;
      end
   end

   pipe_entry_reg #(.W(EW)) u_main (
      .clk     (clk),
      .reset   (reset),
      .load    (main_load),
      .clear   (main_clear),
      .d       (main_d),
      .valid   (main_v),
      .payload (main_payload)
   );

   if (SKID != 0) begin : g_skid
      pipe_entry_reg #(.W(EW)) u_skid (
         .clk     (clk),
         .reset   (reset),
         .load    (skid_load),
         .clear   (skid_clear),
         .d       (in_payload),
         .valid   (skid_v),
         .payload (skid_payload)
      );
   end else begin : g_no_skid
      assign skid_v       = 1'b0;
      assign skid_payload = '0;
   end

   assign head_ctrl = main_payload[CTRL_W-1:0];
   assign head_rd   = main_payload[CTRL_W +: RD_W];
   assign out_valid = main_v;
   assign out_rd    = head_rd;
   assign out_data  = main_payload[EW-1 -: DW];

   // Bubbles never write; optionally suppress writes to x0.
   always_comb begin
      out_ctrl = '0;
      if (main_v) begin
         out_ctrl = head_ctrl;
         if (MASK_X0 != 0 && head_rd == '0) out_ctrl[CTRL_WE_BIT] = 1'b0;
      end
   end

   // Stall counter: saturates at all-ones, only reset clears it.
   always_comb begin
      cnt_d = cnt_q;
      if (main_v && !out_ready && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
   end

   // Stall counter register.
   always_ff @(posedge clk) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg (SKID=1, MASK_X0=1, small stall counter).
module tb_pipe_stage_reg;

   localparam int DATA_W   = 32;
   localparam int NUM_DATA = 3;
   localparam int RD_W     = 5;
   localparam int CTRL_W   = 3;
   localparam int CNT_W    = 4;
   localparam int DW       = NUM_DATA * DATA_W;
   localparam int CNT_MAX  = (1 << CNT_W) - 1;

   logic              clk = 1'b0;
   logic              reset, flush, in_valid, in_ready, out_valid, out_ready;
   logic [DW-1:0]     in_data, out_data;
   logic [RD_W-1:0]   in_rd, out_rd;
   logic [CTRL_W-1:0] in_ctrl, out_ctrl;
   logic [CNT_W-1:0]  stall_cnt;

   int checks = 0;
   int failures = 0;

   // Reference model state: occupancy, expected entries, stall count.
   logic [DW+RD_W+CTRL_W-1:0] exp_q[$];
   int occ = 0;
   int cnt_m = 0;
   bit acc_pend = 0;

   always #5 clk = ~clk;

   pipe_stage_reg #(
      .DATA_W(DATA_W), .NUM_DATA(NUM_DATA), .RD_W(RD_W), .CTRL_W(CTRL_W),
      .SKID(1), .MASK_X0(1), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_rd(in_rd), .in_ctrl(in_ctrl),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_rd(out_rd), .out_ctrl(out_ctrl),
      .stall_cnt(stall_cnt)
   );

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Monitor: compares the DUT against the model between clock edges.
   always @(negedge clk) begin
      bit drn, acc;
      logic [DW+RD_W+CTRL_W-1:0] e;
      if (reset) begin
         chk("rst_out_valid", out_valid, 0);
         chk("rst_in_ready", in_ready, 0);
         chk("rst_outputs", {out_data, out_rd, out_ctrl, stall_cnt}, 0);
         occ = 0;
         cnt_m = 0;
         exp_q.delete();
         acc_pend = 0;
      end else begin
         chk("out_valid", out_valid, occ != 0);
         chk("in_ready", in_ready, !flush && occ < 2);
         chk("stall_cnt", stall_cnt, cnt_m);
         if (occ == 0) chk("bubble_ctrl", out_ctrl, 0);
         drn = occ != 0 && out_ready;
         acc = in_valid && !flush && occ < 2;
         if (occ != 0 && !out_ready && cnt_m != CNT_MAX) cnt_m++;
         if (flush) begin
            occ = 0;
            exp_q.delete();
         end else begin
            if (drn) begin
               if (exp_q.size() == 0) begin
                  chk("sb_underflow", 1, 0);
               end else begin
                  e = exp_q.pop_front();
                  chk("out_entry", {out_data, out_rd, out_ctrl}, e);
               end
               occ--;
            end
            if (acc) occ++;
         end
         acc_pend = acc;
      end
   end

   // Stimulus side of the scoreboard: record each accepted entry.
   always @(negedge clk) begin
      logic [CTRL_W-1:0] c;
      #1;
      if (acc_pend) begin
         c = in_ctrl;
         if (in_rd == 0) c[0] = 1'b0;
         exp_q.push_back({in_data, in_rd, c});
      end
   end

   function automatic logic [RD_W-1:0] rnd_rd();
      return ($urandom_range(0, 3) == 0) ? '0 : RD_W'($urandom_range(1, 31));
   endfunction

   task automatic step(input logic v, input logic r, input logic f,
                       input logic [RD_W-1:0] rd, input logic [CTRL_W-1:0] c);
      in_valid  = v;
      out_ready = r;
      flush     = f;
      in_rd     = rd;
      in_ctrl   = c;
      in_data   = {$urandom(), $urandom(), $urandom()};
      @(posedge clk);
      #1;
   endtask

   task automatic rstep(input logic v, input logic r, input logic f);
      step(v, r, f, rnd_rd(), CTRL_W'($urandom_range(0, 7)));
   endtask

   initial begin
      reset = 1'b1;
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      reset = 1'b0;

      // Streaming with downstream always ready.
      for (int i = 0; i < 8; i++) rstep(1, 1, 0);
      rstep(0, 1, 0);
      rstep(0, 1, 0);

      // Backpressure fills MAIN and SKID, then drains in order.
      for (int i = 0; i < 4; i++) rstep(1, 0, 0);
      for (int i = 0; i < 3; i++) rstep(0, 1, 0);

      // Flush with both entries full and an entry offered.
      rstep(1, 0, 0);
      rstep(1, 0, 0);
      rstep(1, 0, 1);
      rstep(1, 1, 0);
      rstep(0, 1, 0);
      rstep(0, 1, 0);

      // x0 write-enable masking.
      step(1, 1, 0, 0, 3'b001);
      step(1, 1, 0, 5, 3'b001);
      step(1, 1, 0, 0, 3'b111);
      rstep(0, 1, 0);
      rstep(0, 1, 0);

      // Long stall saturates the counter.
      rstep(1, 0, 0);
      for (int i = 0; i < CNT_MAX + 4; i++) rstep(0, 0, 0);
      @(negedge clk);
      chk("stall_saturated", stall_cnt, CNT_MAX);
      @(posedge clk);
      #1;
      rstep(0, 1, 1);
      @(negedge clk);
      chk("stall_kept_after_flush", stall_cnt, CNT_MAX);
      @(posedge clk);
      #1;

      // Random traffic.
      for (int i = 0; i < 400; i++)
         rstep($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
      for (int i = 0; i < 4; i++) rstep(0, 1, 0);

      @(negedge clk);
      #2;
      chk("final_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
